// File: rtl/led_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_fade_ctrl
// Purpose  : N-channel PWM LED bank with per-channel fade toward a target.
//            Optional gamma-corrected duty when LED_FADE_GAMMA_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module led_fade_ctrl #(
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000,
  localparam int C_LED_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [C_LED_W-1:0]  cmd_led,
  input  logic [PWM_BITS-1:0] cmd_level,
  output logic [N_LEDS-1:0]   ledb,
  output logic                busy
);

  localparam int C_PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [C_LED_W-1:0]  C_LAST_IDX = C_LED_W'(N_LEDS - 1);
  localparam logic [C_PRE_W-1:0]  C_PRE_LAST = C_PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] C_PWM_MAX  = '1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [C_PRE_W-1:0]    r_pre;
  logic [C_LED_W-1:0]    r_idx;
  logic [PWM_BITS-1:0]   r_pwm;
  logic                  r_busy;
  logic                  w_tick;
  logic                  w_accept;
  logic                  w_pwm_wrap;
  logic                  w_scan;
  logic [N_LEDS-1:0]     w_diff;
  logic [N_LEDS-1:0]     w_led;

  assign w_tick     = (r_pre == C_PRE_LAST);
  assign w_scan     = (r_state == S_SCAN);
  assign w_pwm_wrap = (r_pwm == C_PWM_MAX);
  assign cmd_ready  = (r_state == S_IDLE) && rstn;
  assign w_accept   = cmd_valid && cmd_ready;
  assign ledb       = w_led;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre <= '0;
      r_pwm <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      r_pwm <= r_pwm + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= (w_scan && (r_idx != C_LAST_IDX)) ? r_idx + 1'b1 : '0;
      r_busy  <= |w_diff;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_tick) w_state_nxt = S_SCAN;
      S_SCAN:  if (r_idx == C_LAST_IDX) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Out-of-range indices match no channel, so such commands are dropped.
  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    logic [PWM_BITS-1:0] r_tgt;
    logic [PWM_BITS-1:0] r_cur;
    logic [PWM_BITS-1:0] r_shadow;
    logic [PWM_BITS-1:0] w_duty;
    logic                r_led;
    logic                w_wr;
    logic                w_sel;

    assign w_wr      = w_accept && (cmd_led == C_LED_W'(i));
    assign w_sel     = w_scan && (r_idx == C_LED_W'(i));
    assign w_diff[i] = (r_cur != r_tgt);
    assign w_led[i]  = r_led;

`ifdef LED_FADE_GAMMA_EN
    localparam int C_SQ_W = 2 * PWM_BITS + 1;
    logic [C_SQ_W-1:0] w_sq;
    assign w_sq   = C_SQ_W'(r_cur) * C_SQ_W'(r_cur) + C_SQ_W'(C_PWM_MAX);
    assign w_duty = PWM_BITS'(w_sq >> PWM_BITS);
`else
    assign w_duty = r_cur;
`endif

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_tgt    <= '0;
        r_cur    <= '0;
        r_shadow <= '0;
        r_led    <= 1'b0;
      end else begin
        if (w_wr) r_tgt <= cmd_level;
        if (w_sel) begin
          if (r_cur < r_tgt)      r_cur <= r_cur + 1'b1;
          else if (r_cur > r_tgt) r_cur <= r_cur - 1'b1;
        end
        // Duty is latched only at the period boundary to avoid mid-period glitches.
        if (w_pwm_wrap) r_shadow <= w_duty;
        r_led <= (r_pwm < r_shadow);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/led_fade_ctrl.md
Name: led_fade_ctrl

Overview:
- Controller for the board's 8-LED PWM bank. Holds a target brightness per LED and ramps each LED's current brightness toward its target at a fixed rate.
- One shared PWM counter drives all channels; outputs are the 8 LED lines that the top entity concatenates onto LED7..LED0.
- Brightness changes arrive as single-channel commands over a valid/ready handshake from a user-logic sequencer.

Parameters:
- N_LEDS, 8, number of channels; cmd_led width is clog2(N_LEDS) (3 at default).
- PWM_BITS, 8, PWM resolution; also the width of cmd_level and of each brightness register.
- STEP_DIV, 50000, clk cycles between fade steps (about 4.2 ms at 12 MHz). Must be at least N_LEDS+2.

Ports:
- clk  in  1  system clock (board CLK)
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command this cycle
- cmd_led  in  3  channel index 0..N_LEDS-1
- cmd_level  in  8  new target brightness
- ledb  out  8  LED drive, bit i = LED i, registered
- busy  out  1  some channel's current brightness differs from its target, registered

Behaviour:
- Reset is asynchronous and active-low. While rstn=0 all of the following are 0: PWM counter, prescaler, cur[i], tgt[i], shadow[i], ledb, busy. State is IDLE and cmd_ready=0.
- cmd_ready = (state==IDLE) && rstn, combinational.
- Command handshake:
  - Accepted when cmd_valid && cmd_ready. tgt[cmd_led] <= cmd_level on that edge.
  - If cmd_led >= N_LEDS, the command is accepted and ignored.
  - cmd_led and cmd_level are held stable by the sender only until acceptance.
- Prescaler: counts 0..STEP_DIV-1 and wraps. It pulses tick for one cycle when the count equals STEP_DIV-1.
- FSM:
  - IDLE: on tick, go to SCAN with idx=0. Otherwise stay.
  - SCAN: one channel per cycle, cur[idx] moves one step toward tgt[idx] (+1 if below, -1 if above, unchanged if equal). idx increments each cycle; after idx=N_LEDS-1, go to IDLE. SCAN lasts exactly N_LEDS cycles.
  - Tick together with an accepted command in IDLE: the command is written first. SCAN starts the next cycle and already uses the new target.
- Fade rate: one LSB per channel per tick. Full swing 0 to 255 takes 255 ticks.
- PWM:
  - PWM_BITS-bit counter, free-running, wraps 255 to 0.
  - shadow[i] <= duty(cur[i]) on the cycle the counter equals 255, so duty changes only at period boundaries and never glitch mid-period.
  - ledb[i] <= (pwm_cnt < shadow[i]), registered.
  - Output latency: one clock from counter to ledb.
  - Boundary cases: shadow=0 gives LED constantly off; shadow=255 gives LED on 255 of 256 cycles.
- busy: registered OR over i of (cur[i] != tgt[i]). It is 1 cycle late relative to register updates.
- Reset mid-SCAN: the FSM returns to IDLE immediately and all brightness is cleared. No partial-update recovery is required.
- Widths: cur and tgt never leave 0..255. No wrap is possible because a step only ever moves toward the target.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty(c) = (c*c + 255) >> 8, computed with a 17-bit intermediate. Reference values: duty(0)=0, duty(1)=1, duty(128)=64, duty(255)=255. It is computed combinationally in the shadow-load path; no extra latency.
- Undefined: duty(c) = c (linear). No multiplier is inferred.

Test Plan:
- Reset check, STEP_DIV=10: hold rstn=0 for 5 cycles, with cmd_valid=1 from cycle 2 -> ledb=0, busy=0, cmd_ready=0 throughout; after release, cmd_ready=1 on the first cycle.
- Ramp up, STEP_DIV=10: command led 3, level 4 -> busy rises 1 cycle after acceptance; cur[3] reaches 4 after 4 ticks; busy falls; ledb[3] is high for exactly 4 of 256 cycles in the period after the next counter wrap.
- Ramp down and retarget: ramp led 0 to 10, then command level 2, then command level 6 when cur=5 -> cur sequence 10,9,8,7,6,5,6 and settles at 6 with busy=0.
- Handshake during SCAN: hold cmd_valid=1 across a tick -> cmd_ready=0 for exactly N_LEDS=8 cycles; the command is accepted on the first IDLE cycle, and only once.
- Simultaneous tick and command: command led 7, level 1 on the prescaler's wrap cycle -> cur[7]=1 after the SCAN that starts on the next cycle. Out-of-range cmd_led: not exercisable at N_LEDS=8 with a 3-bit cmd_led; run it as a separate N_LEDS=6 configuration, index 6 -> tgt and cur unchanged, busy stays 0.
- Extremes: level 255 on all channels, run to settle -> each ledb bit low exactly 1 cycle per 256. Then level 0 -> all LEDs constantly off. With LED_FADE_GAMMA_EN defined, cur=128 -> 64 high cycles per period.
